register_file_param: RTL and testbench
======================================

REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of each register in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, meaning address width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 SHALL have parameter ZERO_REG, default 0, meaning when 1, register 0 is hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1, meaning when 1, a read of the address being written returns write_data in the same cycle.
REQ-005 SHALL have port clk, input, 1 bit, meaning single clock; all state changes occur on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, meaning asynchronous, active-low reset.
REQ-007 SHALL have port RegWrite, input, 1 bit, meaning active-high write enable.
REQ-008 SHALL have port write_addr, input, ADDR_WIDTH bits, meaning write address.
REQ-009 SHALL have port write_data, input, DATA_WIDTH bits, meaning write data.
REQ-010 SHALL have ports read_addr_1 and read_addr_2, input, ADDR_WIDTH bits each, meaning read addresses.
REQ-011 SHALL have ports read_data_1 and read_data_2, output, DATA_WIDTH bits each, meaning combinational read data.
REQ-012 SHALL have port clear, input, 1 bit, meaning a request to start a sweep that zeroes every register.
REQ-013 SHALL have port busy, output, 1 bit, meaning a clear sweep is in progress.

Function
REQ-014 Write: on a rising clk edge with RegWrite=1, reset=1 and state IDLE, the block SHALL load write_data into register[write_addr].
REQ-015 Reads: read_data_n SHALL equal register[read_addr_n] combinationally, with zero latency.
REQ-016 When BYPASS=1, state is IDLE, RegWrite=1 and read_addr_n==write_addr, read_data_n SHALL equal write_data in the same cycle.
REQ-017 When ZERO_REG=1, writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0 even when bypass applies.
REQ-018 The clear engine SHALL be an FSM with states IDLE and SWEEP, plus an ADDR_WIDTH-bit sweep counter.
REQ-019 In IDLE with clear=1, the FSM SHALL move to SWEEP on the next edge and set the counter to 0; a write presented in that same cycle SHALL still be performed.
REQ-020 In SWEEP, each edge SHALL zero register[counter] and increment the counter.
REQ-021 When the counter equals DEPTH-1, the FSM SHALL zero that register and return to IDLE; the sweep SHALL therefore take exactly DEPTH cycles.
REQ-022 busy SHALL be 1 exactly while the state is SWEEP.
REQ-023 In SWEEP, RegWrite SHALL be ignored (the write is dropped), bypass SHALL be disabled, and clear SHALL be ignored.
REQ-024 Reads during SWEEP SHALL return current stored contents, which may be partially cleared.
REQ-025 The counter SHALL NOT wrap past DEPTH-1 and SHALL be 0 in IDLE.
REQ-026 All widths SHALL be exact; read or write addresses outside DEPTH are impossible by construction.

Reset
REQ-027 reset=0 SHALL, asynchronously and without waiting for clk, force all DEPTH registers to 0, state to IDLE, counter to 0 and busy to 0.
REQ-028 Assertion of reset mid-sweep SHALL abort the sweep with the same result as REQ-027.
REQ-029 While reset=0, writes and clear SHALL be ignored, and read_data_n SHALL be 0 except when BYPASS=1 and the bypass condition of REQ-016 holds; the first write is accepted on the first edge after reset=1.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3 unless stated)
REQ-030 Basic write/read: write 0xA5 to r3 and 0x3C to r6, then set read_addr_1=3 and read_addr_2=6 -> read_data_1=0xA5 and read_data_2=0x3C; all other registers read 0.
REQ-031 Bypass: with r2=0x11, set RegWrite=1, write_addr=2, write_data=0x77 and read_addr_1=2 -> read_data_1=0x77 before the edge and after it; with BYPASS=0, read_data_1=0x11 before the edge.
REQ-032 ZERO_REG=1: write 0xFF to r0 -> read of r0 returns 0, including in the same cycle as the write.
REQ-033 Sweep: fill r0..r7 with 0x10..0x17, pulse clear for 1 cycle -> busy is high for exactly 8 cycles; r0 reads 0 after the 1st sweep edge and r4 reads 0x14 until the 5th; a write of 0x99 to r1 during the sweep is dropped; all registers read 0 afterwards.
REQ-034 Reset mid-sweep: assert reset for 1 ns during the 3rd sweep cycle, between clk edges -> busy=0 and all registers read 0 immediately; a subsequent write of 0x42 to r5 succeeds.
REQ-035 Parameter sweep: DATA_WIDTH=32 and ADDR_WIDTH=5 -> write/read of 0xDEADBEEF at r31 works, and the sweep takes 32 cycles.

Source files
------------

// File: rtl/register_file_param.sv
// Parameterised multi-port register file with write-through bypass, an optional
// hardwired zero register and a sequential clear engine that zeroes one register per cycle.
module register_file_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter bit ZERO_REG   = 1'b0,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    input  logic                  clear,
    output logic                  busy
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] counter;
    logic [ADDR_WIDTH-1:0] counter_next;
    logic [DATA_WIDTH-1:0] regs [DEPTH];

    logic idle;
    logic write_en;
    logic hit_1;
    logic hit_2;

    assign idle = (state == IDLE);

    // Writes only land while idle; register 0 silently absorbs writes when hardwired.
    assign write_en = idle && RegWrite && !(ZERO_REG && (write_addr == '0));

    // Clear engine: state register and sweep counter.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        unique case (state)
            IDLE: begin
                counter_next = '0;
                if (clear) begin
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                if (counter == LAST_ADDR) begin
                    state_next   = IDLE;
                    counter_next = '0;
                end else begin
                    counter_next = counter + 1'b1;
                end
            end
        endcase
    end

    assign busy = (state == SWEEP);

    // Storage: the sweep owns the array while active, so writes cannot race it.
    // NOTE: the array is reset element by element so an asserted reset clears all
    // registers at once; this keeps the storage in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == SWEEP) begin
            regs[counter] <= '0;
        end else if (write_en) begin
            regs[write_addr] <= write_data;
        end
    end

    // Bypass is suppressed during a sweep; reset forces IDLE, so it stays live in reset.
    assign hit_1 = BYPASS && idle && RegWrite && (read_addr_1 == write_addr);
    assign hit_2 = BYPASS && idle && RegWrite && (read_addr_2 == write_addr);

    always_comb begin
        read_data_1 = hit_1 ? write_data : regs[read_addr_1];
        if (ZERO_REG && (read_addr_1 == '0)) begin
            read_data_1 = '0;
        end
    end

    always_comb begin
        read_data_2 = hit_2 ? write_data : regs[read_addr_2];
        if (ZERO_REG && (read_addr_2 == '0)) begin
            read_data_2 = '0;
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// Self-checking bench for register_file_param: table vectors, directed sweep/reset
// sequences and randomized traffic against an array-based reference model.
module tb_register_file_param;

    logic       clk;
    logic       reset;
    logic       reg_write;
    logic [2:0] write_addr;
    logic [7:0] write_data;
    logic [2:0] read_addr_1;
    logic [2:0] read_addr_2;
    logic       clear;

    logic [7:0] rd1_d, rd2_d, rd1_n, rd2_n, rd1_z, rd2_z;
    logic       busy_d, busy_n, busy_z;

    logic        w_we;
    logic [4:0]  w_wa, w_ra1, w_ra2;
    logic [31:0] w_wd, w_rd1, w_rd2;
    logic        w_clear, w_busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain array plus a count of sweep cycles still to run.
    logic [7:0] mem [8];
    int         sweep_left;
    int         sweep_idx;

    register_file_param dut_d (
        .clk(clk), .reset(reset), .RegWrite(reg_write), .write_addr(write_addr),
        .write_data(write_data), .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
        .read_data_1(rd1_d), .read_data_2(rd2_d), .clear(clear), .busy(busy_d)
    );

    register_file_param #(.BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset), .RegWrite(reg_write), .write_addr(write_addr),
        .write_data(write_data), .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
        .read_data_1(rd1_n), .read_data_2(rd2_n), .clear(clear), .busy(busy_n)
    );

    register_file_param #(.ZERO_REG(1'b1)) dut_z (
        .clk(clk), .reset(reset), .RegWrite(reg_write), .write_addr(write_addr),
        .write_data(write_data), .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
        .read_data_1(rd1_z), .read_data_2(rd2_z), .clear(clear), .busy(busy_z)
    );

    register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut_w (
        .clk(clk), .reset(reset), .RegWrite(w_we), .write_addr(w_wa),
        .write_data(w_wd), .read_addr_1(w_ra1), .read_addr_2(w_ra2),
        .read_data_1(w_rd1), .read_data_2(w_rd2), .clear(w_clear), .busy(w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        sweep_left = 0;
        sweep_idx  = 0;
    endtask

    task automatic model_edge();
        if (sweep_left > 0) begin
            mem[sweep_idx] = 8'h00;
            sweep_idx++;
            sweep_left--;
        end else begin
            if (reg_write) mem[write_addr] = write_data;
            if (clear) begin
                sweep_left = 8;
                sweep_idx  = 0;
            end
        end
    endtask

    function automatic logic [7:0] exp_read(input logic [2:0] ra, input bit bypass, input bit zero);
        if (zero && ra == 3'd0) return 8'h00;
        if (bypass && sweep_left == 0 && reg_write && ra == write_addr) return write_data;
        return mem[ra];
    endfunction

    task automatic check_model(input string tag);
        check($sformatf("%s rd1 default", tag), rd1_d, exp_read(read_addr_1, 1'b1, 1'b0));
        check($sformatf("%s rd2 default", tag), rd2_d, exp_read(read_addr_2, 1'b1, 1'b0));
        check($sformatf("%s rd1 nobypass", tag), rd1_n, exp_read(read_addr_1, 1'b0, 1'b0));
        check($sformatf("%s rd2 nobypass", tag), rd2_n, exp_read(read_addr_2, 1'b0, 1'b0));
        check($sformatf("%s rd1 zeroreg", tag), rd1_z, exp_read(read_addr_1, 1'b1, 1'b1));
        check($sformatf("%s rd2 zeroreg", tag), rd2_z, exp_read(read_addr_2, 1'b1, 1'b1));
        check($sformatf("%s busy", tag), {busy_d, busy_n, busy_z}, (sweep_left > 0) ? 3'b111 : 3'b000);
    endtask

    // One rising edge; the model sees the same pre-edge inputs as the DUTs.
    task automatic tick();
        @(posedge clk);
        if (reset) model_edge();
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        #1;
        reset = 1'b1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        reg_write  = 1'b1;
        write_addr = a;
        write_data = d;
        tick();
        reg_write  = 1'b0;
    endtask

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] e1_nb;
        logic [7:0] e2_nb;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int edges;

        vecs[0]  = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd6, 8'hA5, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 3'd6, 8'h3C, 3'd3, 3'd6, 8'hA5, 8'h3C, 8'hA5, 8'h00};
        vecs[2]  = '{1'b0, 3'd0, 8'hFF, 3'd3, 3'd6, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[3]  = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd4, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd7, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[6]  = '{1'b1, 3'd2, 8'h11, 3'd2, 3'd3, 8'h11, 8'hA5, 8'h00, 8'hA5};
        vecs[7]  = '{1'b1, 3'd2, 8'h77, 3'd2, 3'd2, 8'h77, 8'h77, 8'h11, 8'h11};
        vecs[8]  = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd6, 8'h77, 8'h3C, 8'h77, 8'h3C};
        vecs[9]  = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd3, 8'hFF, 8'hA5, 8'h00, 8'hA5};
        vecs[10] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 8'hFF, 8'h00, 8'hFF, 8'h00};

        // Reset held: writes and clear ignored, bypass still visible.
        model_reset();
        reset       = 1'b0;
        reg_write   = 1'b1;
        write_addr  = 3'd3;
        write_data  = 8'h5A;
        read_addr_1 = 3'd3;
        read_addr_2 = 3'd4;
        clear       = 1'b1;
        w_we = 1'b0; w_wa = '0; w_wd = '0; w_ra1 = '0; w_ra2 = '0; w_clear = 1'b0;
        #2;
        check("reset bypass rd1", rd1_d, 8'h5A);
        check("reset nobypass rd1", rd1_n, 8'h00);
        check("reset rd2", rd2_d, 8'h00);
        check("reset busy", {busy_d, w_busy}, 2'b00);
        tick();
        reg_write = 1'b0;
        clear     = 1'b0;
        #1;
        check("write during reset ignored", rd1_d, 8'h00);
        check("clear during reset ignored", busy_d, 1'b0);
        reset = 1'b1;

        // Table vectors: reads are checked before the edge, which shows bypass.
        for (int i = 0; i < 11; i++) begin
            reg_write   = vecs[i].we;
            write_addr  = vecs[i].wa;
            write_data  = vecs[i].wd;
            read_addr_1 = vecs[i].ra1;
            read_addr_2 = vecs[i].ra2;
            #1;
            check($sformatf("vec%0d rd1", i), rd1_d, vecs[i].e1);
            check($sformatf("vec%0d rd2", i), rd2_d, vecs[i].e2);
            check($sformatf("vec%0d rd1 nobypass", i), rd1_n, vecs[i].e1_nb);
            check($sformatf("vec%0d rd2 nobypass", i), rd2_n, vecs[i].e2_nb);
            check($sformatf("vec%0d rd1 zeroreg", i), rd1_z, (vecs[i].ra1 == 3'd0) ? 8'h00 : vecs[i].e1);
            check($sformatf("vec%0d rd2 zeroreg", i), rd2_z, (vecs[i].ra2 == 3'd0) ? 8'h00 : vecs[i].e2);
            tick();
        end
        reg_write = 1'b0;

        // Full sweep with a dropped write in the middle.
        pulse_reset();
        for (int i = 0; i < 8; i++) write_reg(3'(i), 8'h10 + 8'(i));
        clear       = 1'b1;
        read_addr_1 = 3'd4;
        read_addr_2 = 3'd0;
        #1;
        check("pre-clear busy", busy_d, 1'b0);
        check("pre-clear r4", rd1_d, 8'h14);
        check_model("pre-clear");
        tick();
        clear = 1'b0;
        #1;
        check("busy after clear edge", busy_d, 1'b1);
        edges = 0;
        while (busy_d && edges < 20) begin
            tick();
            edges++;
            if (!busy_d) begin
                reg_write = 1'b0;
            end else if (edges == 2) begin
                reg_write   = 1'b1;
                write_addr  = 3'd1;
                write_data  = 8'h99;
                read_addr_2 = 3'd1;
            end
            #1;
            check($sformatf("sweep edge%0d r4", edges), rd1_d, (edges >= 5) ? 8'h00 : 8'h14);
            check($sformatf("sweep edge%0d r0/r1", edges), rd2_d, 8'h00);
            check_model($sformatf("sweep edge%0d", edges));
        end
        check("sweep length", edges, 8);
        for (int i = 0; i < 8; i++) begin
            read_addr_1 = 3'(i);
            #1;
            check($sformatf("after sweep r%0d", i), rd1_d, 8'h00);
        end

        // Reset asserted between edges during the third sweep cycle.
        tick();
        pulse_reset();
        for (int i = 0; i < 8; i++) write_reg(3'(i), 8'h20 + 8'(i));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tick();
        read_addr_1 = 3'd5;
        read_addr_2 = 3'd7;
        #2;
        check("mid-sweep busy before reset", busy_d, 1'b1);
        reset = 1'b0;
        model_reset();
        #1;
        check("abort busy", busy_d, 1'b0);
        check("abort r5", rd1_d, 8'h00);
        check("abort r7", rd2_d, 8'h00);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            read_addr_1 = 3'(i);
            #1;
            check($sformatf("after abort r%0d", i), rd1_d, 8'h00);
        end
        write_reg(3'd5, 8'h42);
        read_addr_1 = 3'd5;
        #1;
        check("write after abort", rd1_d, 8'h42);
        check_model("after abort");

        // Wide instance: 32-bit data, 32 registers.
        w_we  = 1'b1;
        w_wa  = 5'd31;
        w_wd  = 32'hDEADBEEF;
        w_ra1 = 5'd31;
        w_ra2 = 5'd30;
        #1;
        check("wide bypass r31", w_rd1, 32'hDEADBEEF);
        tick();
        w_we = 1'b0;
        #1;
        check("wide r31", w_rd1, 32'hDEADBEEF);
        check("wide r30", w_rd2, 32'h0);
        w_clear = 1'b1;
        tick();
        w_clear = 1'b0;
        edges = 0;
        while (w_busy && edges < 100) begin
            tick();
            edges++;
        end
        check("wide sweep length", edges, 32);
        check("wide r31 cleared", w_rd1, 32'h0);

        // Randomized traffic against the model, with rare clears and resets.
        for (int i = 0; i < 300; i++) begin
            reg_write   = 1'($urandom_range(0, 1));
            write_addr  = 3'($urandom_range(0, 7));
            write_data  = 8'($urandom);
            read_addr_1 = 3'($urandom_range(0, 7));
            read_addr_2 = ($urandom_range(0, 3) == 0) ? write_addr : 3'($urandom_range(0, 7));
            clear       = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) pulse_reset();
            #1;
            check_model($sformatf("rand%0d", i));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
